// File: rtl/matrix_mul_seq_if.sv
// matrix_mul_seq_if: operand/result handshake bundle for the 4x4 matrix multiplier
// in_valid/in_ready/mode/matA/matB: operand side; out_valid/out_ready/res_mat/overflow: result side
// master drives operands and accepts results; slave is the multiplier
interface matrix_mul_seq_if #(
  parameter int WI = 16,
  parameter int WO = 16
);
  logic in_valid;
  logic in_ready;
  logic mode;
  logic [15:0][WI-1:0] matA;
  logic [15:0][WI-1:0] matB;
  logic out_valid;
  logic out_ready;
  logic [15:0][WO-1:0] res_mat;
  logic overflow;
  modport master (
    output in_valid, mode, matA, matB, out_ready,
    input  in_ready, out_valid, res_mat, overflow
  );
  modport slave (
    input  in_valid, mode, matA, matB, out_ready,
    output in_ready, out_valid, res_mat, overflow
  );
endinterface

// File: rtl/matrix_mul_seq.sv
// matrix_mul_seq: sequential handshaked 4x4 fixed-point matrix multiplier, LANES dot products per cycle
// Clk, Reset (sync, active-high); bus: slave side of matrix_mul_seq_if
// mode 0 = A*B (16 results), mode 1 = A*v with v = column 0 of B
module matrix_mul_seq #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int LANES = 4,
  parameter int SAT   = 1
) (
  input logic Clk,
  input logic Reset,
  matrix_mul_seq_if.slave bus
);
  localparam int WI   = WII + WIF;
  localparam int WO   = WOI + WOF;
  localparam int PW   = 2 * WI;
  localparam int AW   = PW + 3;
  localparam int SH   = 2 * WIF - WOF;
  localparam int SHR  = SH > 0 ? SH : 0;
  localparam int SHM  = SHR > 0 ? SHR - 1 : 0;
  localparam int LSH  = SH < 0 ? -SH : 0;
  localparam int RW0  = AW + LSH;
  localparam int RW   = RW0 > WO + 1 ? RW0 : WO + 1;
  localparam logic signed [RW-1:0] RND  = RW'(SHR > 0) <<< SHM;
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (WO - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  logic ovf_q, ovf_d;
  logic [15:0][WI-1:0] a_q, a_d, b_q, b_d;
  logic [15:0][WO-1:0] res_q, res_d;
  int idx, e, n;
  logic signed [PW-1:0] p;
  logic signed [AW-1:0] acc;
  logic [WO:0] f;
  // rescale a full-precision sum to the output format; returns {overflow, value}
  function automatic logic [WO:0] fix(input logic signed [AW-1:0] s);
    logic signed [RW-1:0] r;
    logic hi, lo;
    logic [WO-1:0] v;
    r = RW'(s);
    r = (r + RND) >>> SHR;
    r = r <<< LSH;
    hi = r > MAXV;
    lo = r < MINV;
    v = r[WO-1:0];
    if (SAT != 0 && hi) v = {1'b0, {(WO-1){1'b1}}};
    if (SAT != 0 && lo) v = {1'b1, {(WO-1){1'b0}}};
    return {hi | lo, v};
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    ovf_d = ovf_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    idx = 0;
    e = 0;
    n = mode_q ? 4 : 16;
    p = '0;
    acc = '0;
    f = '0;
    bus.in_ready = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.res_mat = res_q;
    bus.overflow = ovf_q;
    if (state_q == IDLE && bus.in_valid) begin
      a_d = bus.matA;
      b_d = bus.matB;
      mode_d = bus.mode;
      res_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
      state_d = COMPUTE;
    end
    if (state_q == COMPUTE) begin
      for (int l = 0; l < LANES; l++) begin
        idx = int'(cnt_q) * LANES + l;
        e = mode_q ? idx * 4 : idx;
        if (idx < n) begin
          acc = '0;
          for (int k = 0; k < 4; k++) begin
            p = PW'(signed'(a_q[(e / 4) * 4 + k])) * PW'(signed'(b_q[k * 4 + e % 4]));
            acc = acc + AW'(p);
          end
          f = fix(acc);
          res_d[e] = f[WO-1:0];
          ovf_d = ovf_d | f[WO];
        end
      end
      cnt_d = cnt_q + 5'd1;
      state_d = (int'(cnt_q) + 1) * LANES >= n ? DONE : COMPUTE;
    end
    if (state_q == DONE && bus.out_ready) state_d = IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mode_q <= 1'b0;
      ovf_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      ovf_q <= ovf_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_matrix_mul_seq.sv
// tb_matrix_mul_seq: directed checks of matrix_mul_seq with LANES=1/4/16 (SAT=1/1/0) driven in lockstep
module tb_matrix_mul_seq;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0][15:0] ma = '0;
  logic [15:0][15:0] mb = '0;
  logic [2:0] ov, ir, of;
  logic [15:0][15:0] res [3];
  logic [15:0][15:0] exp_r [3];
  logic [2:0] exp_o;
  int lat [3];
  int lanes [3] = '{1, 4, 16};
  int errors = 0;
  int checks = 0;
  always #5 Clk = ~Clk;
  matrix_mul_seq_if #(.WI(16), .WO(16)) if0 ();
  matrix_mul_seq_if #(.WI(16), .WO(16)) if1 ();
  matrix_mul_seq_if #(.WI(16), .WO(16)) if2 ();
  assign if0.in_valid = in_valid;
  assign if1.in_valid = in_valid;
  assign if2.in_valid = in_valid;
  assign if0.mode = mode;
  assign if1.mode = mode;
  assign if2.mode = mode;
  assign if0.matA = ma;
  assign if1.matA = ma;
  assign if2.matA = ma;
  assign if0.matB = mb;
  assign if1.matB = mb;
  assign if2.matB = mb;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;
  assign ov = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign ir = {if2.in_ready, if1.in_ready, if0.in_ready};
  assign of = {if2.overflow, if1.overflow, if0.overflow};
  assign res[0] = if0.res_mat;
  assign res[1] = if1.res_mat;
  assign res[2] = if2.res_mat;
  matrix_mul_seq #(.LANES(1), .SAT(1)) u0 (.Clk(Clk), .Reset(Reset), .bus(if0));
  matrix_mul_seq #(.LANES(4), .SAT(1)) u1 (.Clk(Clk), .Reset(Reset), .bus(if1));
  matrix_mul_seq #(.LANES(16), .SAT(0)) u2 (.Clk(Clk), .Reset(Reset), .bus(if2));

  task automatic run_op(input logic m, input logic [15:0][15:0] a, input logic [15:0][15:0] b, input string name);
    int want;
    @(negedge Clk);
    mode = m;
    ma = a;
    mb = b;
    in_valid = 1'b1;
    checks++;
    if (ir !== 3'b111) begin errors++; $display("FAIL %s in_ready before accept: got %b want 111", name, ir); end
    @(negedge Clk);
    in_valid = 1'b0;
    lat = '{0, 0, 0};
    for (int k = 1; k <= 40; k++) begin
      for (int i = 0; i < 3; i++) if (ov[i] === 1'b1 && lat[i] == 0) lat[i] = k;
      if (ov === 3'b111) break;
      @(negedge Clk);
    end
    for (int i = 0; i < 3; i++) begin
      want = ((m ? 4 : 16) + lanes[i] - 1) / lanes[i] + 1;
      checks++;
      if (lat[i] != want) begin errors++; $display("FAIL %s latency dut%0d: got %0d want %0d", name, i, lat[i], want); end
      checks++;
      if (res[i] !== exp_r[i]) begin errors++; $display("FAIL %s res_mat dut%0d: got %h want %h", name, i, res[i], exp_r[i]); end
      checks++;
      if (of[i] !== exp_o[i]) begin errors++; $display("FAIL %s overflow dut%0d: got %b want %b", name, i, of[i], exp_o[i]); end
    end
  endtask

  task automatic finish_op(input string name);
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    checks++;
    if (ov !== 3'b000 || ir !== 3'b111) begin errors++; $display("FAIL %s after handshake: out_valid=%b in_ready=%b want 000/111", name, ov, ir); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== exp_r[i]) begin errors++; $display("FAIL %s res held dut%0d: got %h want %h", name, i, res[i], exp_r[i]); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if (ir !== 3'b111 || ov !== 3'b000 || of !== 3'b000) begin errors++; $display("FAIL reset flags: in_ready=%b out_valid=%b overflow=%b want 111/000/000", ir, ov, of); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== '0) begin errors++; $display("FAIL reset res_mat dut%0d: got %h want 0", i, res[i]); end
    end
    Reset = 1'b0;
  endtask

  task automatic test_identity();
    logic [15:0][15:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
      b[i] = 16'(i << 8);
    end
    exp_r = '{b, b, b};
    exp_o = 3'b000;
    run_op(1'b0, a, b, "identity");
    finish_op("identity");
  endtask

  task automatic test_uniform();
    logic [15:0][15:0] a, b, r;
    a = {16{16'h0200}};
    b = {16{16'h0300}};
    r = {16{16'h1800}};
    exp_r = '{r, r, r};
    exp_o = 3'b000;
    run_op(1'b0, a, b, "uniform_pos");
    finish_op("uniform_pos");
    a = {16{16'hFE00}};
    r = {16{16'hE800}};
    exp_r = '{r, r, r};
    run_op(1'b0, a, b, "uniform_neg");
    finish_op("uniform_neg");
  endtask

  task automatic test_round();
    logic [15:0][15:0] a, b, r;
    a = '0;
    b = '0;
    r = '0;
    a[0] = 16'h0001;
    b[0] = 16'h0080;
    r[0] = 16'h0001;
    exp_r = '{r, r, r};
    exp_o = 3'b000;
    run_op(1'b0, a, b, "round");
    finish_op("round");
  endtask

  task automatic test_saturate();
    logic [15:0][15:0] a, rs, rw;
    a = {16{16'h7F00}};
    rs = {16{16'h7FFF}};
    rw = {16{16'h0400}};
    exp_r = '{rs, rs, rw};
    exp_o = 3'b111;
    run_op(1'b0, a, a, "overflow");
    finish_op("overflow");
  endtask

  task automatic test_mode1();
    logic [15:0][15:0] a, b, r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      a[i] = 16'(((i % 4) + 1) << 8);
      b[i] = (i % 4 == 0) ? 16'h0100 : 16'h5500;
      if (i % 4 == 0) r[i] = 16'h0A00;
    end
    exp_r = '{r, r, r};
    exp_o = 3'b000;
    run_op(1'b1, a, b, "mode1");
    finish_op("mode1");
  endtask

  task automatic test_backpressure();
    logic [15:0][15:0] a, b, r;
    a = {16{16'h0100}};
    b = {16{16'h0040}};
    r = {16{16'h0100}};
    exp_r = '{r, r, r};
    exp_o = 3'b000;
    run_op(1'b0, a, b, "backpressure");
    in_valid = 1'b1;
    ma = {16{16'h0300}};
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      checks++;
      if (ov !== 3'b111 || ir !== 3'b000) begin errors++; $display("FAIL stall cycle %0d: out_valid=%b in_ready=%b want 111/000", c, ov, ir); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res[i] !== exp_r[i]) begin errors++; $display("FAIL stall res dut%0d cycle %0d: got %h want %h", i, c, res[i], exp_r[i]); end
      end
    end
    in_valid = 1'b0;
    finish_op("backpressure");
  endtask

  task automatic test_reset_compute();
    @(negedge Clk);
    mode = 1'b0;
    ma = {16{16'h0100}};
    mb = {16{16'h0100}};
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    checks++;
    if (ov !== 3'b000 || ir !== 3'b000) begin errors++; $display("FAIL compute state: out_valid=%b in_ready=%b want 000/000", ov, ir); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (ov !== 3'b000 || ir !== 3'b111 || of !== 3'b000) begin errors++; $display("FAIL abort flags: out_valid=%b in_ready=%b overflow=%b want 000/111/000", ov, ir, of); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== '0) begin errors++; $display("FAIL abort res dut%0d: got %h want 0", i, res[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_uniform();
    test_round();
    test_saturate();
    test_mode1();
    test_backpressure();
    test_reset_compute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
